// File: rtl/perf_counter_bank.sv
// perf_counter_bank: gated cycle counter plus NUM_CH event counters with shadows.
// Define PERF_CNT_SAT_EN to saturate counters at all-ones instead of wrapping.
module perf_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 32,
  localparam int SW = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] event_in,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [SW-1:0]     rd_sel,
  output logic [WIDTH-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic              running,
  output logic              snap_valid
);

  localparam int NC = NUM_CH + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;

  logic [NC-1:0][WIDTH-1:0] cnt_q;
  logic [NC-1:0][WIDTH-1:0] cnt_d;
  logic [NC-1:0][WIDTH-1:0] shd_q;
  logic [NC-1:0]            ovf_q;
  logic [NC-1:0]            ovf_d;
  logic [NC-1:0]            inc;

  logic is_start;
  logic is_stop;
  logic is_clear;
  logic is_snap;

  always_comb begin
    is_start = 1'b0;
    is_stop  = 1'b0;
    is_clear = 1'b0;
    is_snap  = 1'b0;
    if (cmd_valid) begin
      unique case (cmd_op)
        2'd0: is_start = 1'b1;
        2'd1: is_stop  = 1'b1;
        2'd2: is_clear = 1'b1;
        2'd3: is_snap  = 1'b1;
      endcase
    end
  end

  // slot 0 is the cycle counter, slot k+1 is event channel k
  always_comb begin
    inc[0] = (state == RUN);
    for (int k = 0; k < NUM_CH; k++) begin
      inc[k+1] = (state == RUN) & event_in[k] & ch_en[k];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NC; i++) begin
      if (is_clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
        end
`ifdef PERF_CNT_SAT_EN
        if (!(&cnt_q[i])) begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
`else
        cnt_d[i] = cnt_q[i] + WIDTH'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (is_stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
      endcase
    end
  end

  // shadows take the value held before this edge's increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      ovf_q      <= '0;
      shd_q      <= '0;
      snap_valid <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      snap_valid <= is_snap;
      if (is_snap) begin
        shd_q <= cnt_q;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NC; i++) begin
      if (rd_sel == SW'(i)) begin
        rd_data = shd_q[i];
      end
    end
  end

  assign ovf = ovf_q;

endmodule
